// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32 register-file write-port controller.
//   REG_IDX_W / NUM_REGS / XLEN : register-file geometry
//   reg_idx_t                   : architectural register index
//   wb_req_t                    : one writeback request {valid, index, data}
//   idx_onehot()                : index to one-hot register mask
package rv32_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned XLEN      = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic            valid;
        reg_idx_t        index;
        logic [XLEN-1:0] data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] idx_onehot(input reg_idx_t idx);
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/rv32_mod_wb_arbiter.sv
// Fixed-priority mux for the single register-file write port.
// The ALU path cannot be back-pressured, so it always wins. The long-latency
// path is accepted only when the ALU leaves the port free. A starvation
// counter raises drain once the long-latency path has been refused
// STARVE_LIMIT cycles in a row.
//   clk, reset   : clock, synchronous active-high reset
//   alu          : ALU writeback request
//   lat          : long-latency writeback request
//   lat_ready    : long-latency request may be taken this cycle
//   lat_accept   : long-latency request taken this cycle
//   wr           : write-port command (valid acts as the enable)
//   drain        : starvation limit reached, upstream issue must pause
module rv32_mod_wb_arbiter
    import rv32_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic    clk,
    input  logic    reset,
    input  wb_req_t alu,
    input  wb_req_t lat,
    output logic    lat_ready,
    output logic    lat_accept,
    output wb_req_t wr,
    output logic    drain
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic                alu_busy;
    logic [STARVE_W-1:0] starve_cnt;

    // A writeback to x0 is discarded and leaves the port free.
    assign alu_busy   = alu.valid && (alu.index != '0);
    assign lat_ready  = !reset && !alu_busy;
    assign lat_accept = lat.valid && lat_ready;
    assign drain      = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    // Write-port selection; nothing is written while reset is held.
    always_comb begin
        wr = '0;
        if (!reset) begin
            if (alu_busy) begin
                wr = alu;
            end else if (lat.valid) begin
                wr.valid = (lat.index != '0);
                wr.index = lat.index;
                wr.data  = lat.data;
            end
        end
    end

    // Consecutive-refusal counter, saturating at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (lat_accept || !lat.valid) begin
            starve_cnt <= '0;
        end else if (!drain) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/rv32_mod_regfile_scoreboard.sv
// Scoreboard and write-port controller for the 31-entry RV32 register file.
// Tracks destinations of in-flight long-latency ops, stalls issue on
// RAW/WAW hazards against them, and shares the single write port between
// ALU writeback and long-latency completion.
//   clk, reset            : clock, synchronous active-high reset
//   issue_*               : instruction presented by decode; issue_stall holds it
//   alu_wb_*              : ALU writeback (never back-pressured)
//   lat_wb_*              : long-latency completion with valid/ready handshake
//   rf_write0_*           : register-file write port
//   pending / outstanding : scoreboard bitmap and count of in-flight long ops
//   sb_error              : sticky, completion seen for a non-pending register
module rv32_mod_regfile_scoreboard
    import rv32_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 8,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rs1,
    input  logic                 issue_rs1_use,
    input  logic [REG_IDX_W-1:0] issue_rs2,
    input  logic                 issue_rs2_use,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic                 issue_rd_we,
    input  logic                 issue_long,
    output logic                 issue_stall,
    input  logic                 alu_wb_valid,
    input  logic [REG_IDX_W-1:0] alu_wb_index,
    input  logic [XLEN-1:0]      alu_wb_data,
    input  logic                 lat_wb_valid,
    input  logic [REG_IDX_W-1:0] lat_wb_index,
    input  logic [XLEN-1:0]      lat_wb_data,
    output logic                 lat_wb_ready,
    output logic [REG_IDX_W-1:0] rf_write0_index,
    output logic [XLEN-1:0]      rf_write0_data,
    output logic                 rf_write0_enable,
    output logic [NUM_REGS-1:0]  pending,
    output logic [CNT_W-1:0]     outstanding,
    output logic                 sb_error
);

    wb_req_t alu_req;
    wb_req_t lat_req;
    wb_req_t wr;
    logic    lat_accept;
    logic    drain;

    assign alu_req = '{valid: alu_wb_valid, index: alu_wb_index, data: alu_wb_data};
    assign lat_req = '{valid: lat_wb_valid, index: lat_wb_index, data: lat_wb_data};

    rv32_mod_wb_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_wb_arbiter (
        .clk        (clk),
        .reset      (reset),
        .alu        (alu_req),
        .lat        (lat_req),
        .lat_ready  (lat_wb_ready),
        .lat_accept (lat_accept),
        .wr         (wr),
        .drain      (drain)
    );

    assign rf_write0_enable = wr.valid;
    assign rf_write0_index  = wr.index;
    assign rf_write0_data   = wr.data;

    logic                hazard;
    logic                full;
    logic                issue_accept;
    logic                inc;
    logic                dec;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic                orphan;

    // Hazard check uses registered pending only: no same-cycle bypass.
    assign hazard = (issue_rs1_use && pending[issue_rs1])
                 || (issue_rs2_use && pending[issue_rs2])
                 || (issue_rd_we   && pending[issue_rd]);
    assign full   = (outstanding == CNT_W'(MAX_OUTSTANDING));

    assign issue_stall  = reset
                       || (issue_valid && (hazard || (issue_long && full) || drain));
    assign issue_accept = issue_valid && !issue_stall;

    assign inc = issue_accept && issue_long;
    assign dec = lat_accept;

    assign set_mask = (inc && issue_rd_we && (issue_rd != '0))
                    ? idx_onehot(issue_rd) : '0;
    assign clr_mask = (lat_accept && (lat_wb_index != '0))
                    ? idx_onehot(lat_wb_index) : '0;

    // Completion for a register nobody is waiting on.
    assign orphan = lat_accept && (lat_wb_index != '0) && !pending[lat_wb_index];

    // Scoreboard state: bitmap, in-flight count, sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            outstanding <= '0;
            sb_error    <= 1'b0;
        end else begin
            pending <= ((pending & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
            if (inc && !dec) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (dec && !inc) begin
                if (outstanding != '0) begin
                    outstanding <= outstanding - CNT_W'(1);
                end
            end
            if (orphan || (dec && !inc && (outstanding == '0))) begin
                sb_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv32_mod_regfile_scoreboard.sv
module tb_rv32_mod_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic        issue_rs1_use;
    logic [4:0]  issue_rs2;
    logic        issue_rs2_use;
    logic [4:0]  issue_rd;
    logic        issue_rd_we;
    logic        issue_long;
    logic        issue_stall;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_index;
    logic [31:0] alu_wb_data;
    logic        lat_wb_valid;
    logic [4:0]  lat_wb_index;
    logic [31:0] lat_wb_data;
    logic        lat_wb_ready;
    logic [4:0]  rf_write0_index;
    logic [31:0] rf_write0_data;
    logic        rf_write0_enable;
    logic [31:0] pending;
    logic [2:0]  outstanding;
    logic        sb_error;

    int checks = 0;
    int errors = 0;

    rv32_mod_regfile_scoreboard #(
        .MAX_OUTSTANDING (4),
        .STARVE_LIMIT    (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .issue_valid      (issue_valid),
        .issue_rs1        (issue_rs1),
        .issue_rs1_use    (issue_rs1_use),
        .issue_rs2        (issue_rs2),
        .issue_rs2_use    (issue_rs2_use),
        .issue_rd         (issue_rd),
        .issue_rd_we      (issue_rd_we),
        .issue_long       (issue_long),
        .issue_stall      (issue_stall),
        .alu_wb_valid     (alu_wb_valid),
        .alu_wb_index     (alu_wb_index),
        .alu_wb_data      (alu_wb_data),
        .lat_wb_valid     (lat_wb_valid),
        .lat_wb_index     (lat_wb_index),
        .lat_wb_data      (lat_wb_data),
        .lat_wb_ready     (lat_wb_ready),
        .rf_write0_index  (rf_write0_index),
        .rf_write0_data   (rf_write0_data),
        .rf_write0_enable (rf_write0_enable),
        .pending          (pending),
        .outstanding      (outstanding),
        .sb_error         (sb_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs1_use = 0; issue_rs2 = 0;
        issue_rs2_use = 0; issue_rd = 0; issue_rd_we = 0; issue_long = 0;
        alu_wb_valid = 0; alu_wb_index = 0; alu_wb_data = 0;
        lat_wb_valid = 0; lat_wb_index = 0; lat_wb_data = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic we, input logic lng,
                         input logic [4:0] rs1, input logic rs1_use);
        issue_valid = 1; issue_rd = rd; issue_rd_we = we; issue_long = lng;
        issue_rs1 = rs1; issue_rs1_use = rs1_use; issue_rs2 = 0; issue_rs2_use = 0;
    endtask

    task automatic lat(input logic v, input logic [4:0] idx, input logic [31:0] d);
        lat_wb_valid = v; lat_wb_index = idx; lat_wb_data = d;
    endtask

    task automatic alu(input logic v, input logic [4:0] idx, input logic [31:0] d);
        alu_wb_valid = v; alu_wb_index = idx; alu_wb_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        reset = 1;
        tick(); tick();
        // reset forcing of combinational outputs
        alu(1, 5'd3, 32'h55);
        settle();
        check("rst_stall", 32'(issue_stall), 32'd1);
        check("rst_ready", 32'(lat_wb_ready), 32'd0);
        check("rst_wen",   32'(rf_write0_enable), 32'd0);
        idle();
        reset = 0;
        tick();
        check("rst_pending", pending, 32'h0);
        check("rst_outst",   32'(outstanding), 32'd0);
        check("rst_sberr",   32'(sb_error), 32'd0);

        // RAW stall on pending x5, released the cycle after completion
        issue(5'd5, 1, 1, 5'd0, 0);
        settle();
        check("t1_long_stall", 32'(issue_stall), 32'd0);
        tick();
        check("t1_pending", pending, 32'h0000_0020);
        check("t1_outst", 32'(outstanding), 32'd1);
        issue(5'd6, 1, 0, 5'd5, 1);
        settle();
        check("t1_raw_stall", 32'(issue_stall), 32'd1);
        tick();
        lat(1, 5'd5, 32'hDEADBEEF);
        settle();
        check("t1_wen",  32'(rf_write0_enable), 32'd1);
        check("t1_widx", 32'(rf_write0_index), 32'd5);
        check("t1_wdat", rf_write0_data, 32'hDEADBEEF);
        check("t1_nobypass", 32'(issue_stall), 32'd1);
        tick();
        lat(0, 5'd0, 32'h0);
        check("t1_pending_clr", pending, 32'h0);
        check("t1_outst_clr", 32'(outstanding), 32'd0);
        settle();
        check("t1_stall_rel", 32'(issue_stall), 32'd0);
        tick();
        idle();

        // ALU priority over long-latency on the same cycle
        issue(5'd7, 1, 1, 5'd0, 0);
        tick();
        idle();
        alu(1, 5'd3, 32'h11);
        lat(1, 5'd7, 32'h77);
        settle();
        check("t2_widx_alu", 32'(rf_write0_index), 32'd3);
        check("t2_wdat_alu", rf_write0_data, 32'h11);
        check("t2_ready0",   32'(lat_wb_ready), 32'd0);
        tick();
        check("t2_pend_hold", pending, 32'h0000_0080);
        alu(0, 5'd0, 32'h0);
        settle();
        check("t2_widx_lat", 32'(rf_write0_index), 32'd7);
        check("t2_wdat_lat", rf_write0_data, 32'h77);
        check("t2_ready1",   32'(lat_wb_ready), 32'd1);
        tick();
        idle();
        check("t2_pend_clr", pending, 32'h0);

        // starvation: 8 refused cycles raise drain
        issue(5'd8, 1, 1, 5'd0, 0);
        tick();
        idle();
        alu(1, 5'd2, 32'h22);
        lat(1, 5'd8, 32'h88);
        for (int i = 0; i < 7; i++) tick();
        issue(5'd10, 1, 0, 5'd0, 0);
        settle();
        check("t3_no_drain_7", 32'(issue_stall), 32'd0);
        tick();
        check("t3_drain_8", 32'(issue_stall), 32'd1);
        issue_valid = 0;
        settle();
        check("t3_drain_novalid", 32'(issue_stall), 32'd0);
        issue_valid = 1;
        alu(0, 5'd0, 32'h0);
        settle();
        check("t3_drain_hold", 32'(issue_stall), 32'd1);
        check("t3_lat_widx", 32'(rf_write0_index), 32'd8);
        tick();
        lat(0, 5'd0, 32'h0);
        settle();
        check("t3_drain_rel", 32'(issue_stall), 32'd0);
        check("t3_pend_clr", pending, 32'h0);
        tick();
        idle();

        // outstanding limit
        for (int r = 1; r <= 4; r++) begin
            issue(5'(r), 1, 1, 5'd0, 0);
            tick();
        end
        check("t4_outst4", 32'(outstanding), 32'd4);
        check("t4_pend", pending, 32'h0000_001E);
        issue(5'd9, 1, 1, 5'd0, 0);
        settle();
        check("t4_full_stall", 32'(issue_stall), 32'd1);
        issue(5'd10, 1, 0, 5'd11, 1);
        settle();
        check("t4_alu_ok", 32'(issue_stall), 32'd0);
        issue(5'd9, 1, 1, 5'd0, 0);
        lat(1, 5'd1, 32'h1);
        settle();
        check("t4_full_stall2", 32'(issue_stall), 32'd1);
        tick();
        lat(0, 5'd0, 32'h0);
        check("t4_outst3", 32'(outstanding), 32'd3);
        settle();
        check("t4_5th_ok", 32'(issue_stall), 32'd0);
        tick();
        idle();
        check("t4_outst4b", 32'(outstanding), 32'd4);
        check("t4_pend9", pending, 32'h0000_021C);

        // completion for a non-pending register sets sticky error
        lat(1, 5'd12, 32'hC);
        tick();
        lat(0, 5'd0, 32'h0);
        check("t5_sberr", 32'(sb_error), 32'd1);
        check("t5_pend_same", pending, 32'h0000_021C);
        check("t5_outst", 32'(outstanding), 32'd3);
        issue(5'd0, 1, 1, 5'd0, 0);
        tick();
        idle();
        check("t5_x0_outst", 32'(outstanding), 32'd4);
        check("t5_x0_pend", pending, 32'h0000_021C);
        check("t5_sticky", 32'(sb_error), 32'd1);

        // reset mid-operation
        reset = 1;
        tick();
        reset = 0;
        issue(5'd2, 1, 1, 5'd0, 0);
        tick();
        issue(5'd5, 1, 1, 5'd0, 0);
        tick();
        idle();
        check("t6_pend", pending, 32'h0000_0024);
        check("t6_outst", 32'(outstanding), 32'd2);
        reset = 1;
        alu(1, 5'd3, 32'h33);
        issue(5'd9, 1, 0, 5'd0, 0);
        settle();
        check("t6_rst_stall", 32'(issue_stall), 32'd1);
        check("t6_rst_wen", 32'(rf_write0_enable), 32'd0);
        tick();
        check("t6_pend0", pending, 32'h0);
        check("t6_outst0", 32'(outstanding), 32'd0);
        check("t6_sberr0", 32'(sb_error), 32'd0);
        idle();
        reset = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_mod_regfile_scoreboard.md
Name: rv32_mod_regfile_scoreboard

Overview:
Controller for the single write port of the 31-entry RV32 register file (x0 hard-wired zero).
- Tracks destination registers of in-flight long-latency ops (load/mul/div) in a pending bitmap.
- Stalls issue on RAW/WAW hazards against pending registers.
- Arbitrates the one write port between in-order ALU writeback and out-of-order long-latency completion.
- Sits between decode/issue, the execute/completion units and the register file.

Parameters:
MAX_OUTSTANDING, 4, max concurrently pending long-latency ops (1..31)
STARVE_LIMIT, 8, consecutive refused cycles of long-latency writeback before issue is throttled to drain the ALU pipe

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
issue_valid  in  1  decode presents an instruction
issue_rs1  in  5  source 1 index
issue_rs1_use  in  1  rs1 is read
issue_rs2  in  5  source 2 index
issue_rs2_use  in  1  rs2 is read
issue_rd  in  5  destination index
issue_rd_we  in  1  instruction writes rd
issue_long  in  1  instruction completes via long-latency path
issue_stall  out  1  instruction must be held
alu_wb_valid  in  1  ALU writeback this cycle (cannot be back-pressured)
alu_wb_index  in  5  ALU destination
alu_wb_data  in  32  ALU result
lat_wb_valid  in  1  long-latency result offered
lat_wb_index  in  5  its destination
lat_wb_data  in  32  its result
lat_wb_ready  out  1  result accepted this cycle when valid&ready
rf_write0_index  out  5  to register file write port
rf_write0_data  out  32  to register file write port
rf_write0_enable  out  1  to register file write port
pending  out  32  scoreboard bitmap, bit0 always 0
outstanding  out  3  count of pending long ops; width $clog2(MAX_OUTSTANDING+1)
sb_error  out  1  sticky: completion for a non-pending register

Behaviour:
- Reset state, applied the cycle after reset is sampled high: pending=0, outstanding=0, starve_cnt=0, sb_error=0.
- While reset=1, combinationally force issue_stall=1, lat_wb_ready=0, rf_write0_enable=0.
- alu_busy = alu_wb_valid && alu_wb_index!=0. An ALU writeback with index 0 does not occupy the port.
- Write port is combinational, zero latency:
  - alu_busy: index/data from ALU, enable=1.
  - else lat_wb_valid: index/data from lat, enable = (lat_wb_index!=0).
  - else enable=0, index/data=0.
- lat_wb_ready = !reset && !alu_busy. The ALU always has priority.
- lat_accept = lat_wb_valid && lat_wb_ready.
- hazard uses registered pending only. There is no same-cycle bypass: a register freed in cycle N unblocks issue in N+1. hazard is true if any of:
  - issue_rs1_use && pending[rs1]
  - issue_rs2_use && pending[rs2]
  - issue_rd_we && pending[rd]
- issue_stall = issue_valid && (hazard || (issue_long && outstanding==MAX_OUTSTANDING) || drain). Deasserted when issue_valid=0.
- issue_accept = issue_valid && !issue_stall.
- Pending bitmap update:
  - set_mask: bit rd when issue_accept && issue_long && issue_rd_we && rd!=0.
  - clr_mask: bit lat_wb_index when lat_accept && index!=0.
  - pending <= (pending & ~clr_mask) | set_mask.
  - The same index cannot be set and cleared together, because WAW stalls; set wins if it happens.
- outstanding:
  - +1 on issue_accept && issue_long, including long ops with no rd write.
  - -1 on lat_accept.
  - Both in one cycle: unchanged.
  - Never wraps. Decrement at 0 is ignored and sets sb_error.
- sb_error is set when lat_accept && index!=0 && !pending[index]. It stays set until reset.
- Starvation control:
  - starve_cnt increments while lat_wb_valid && !lat_wb_ready, saturating at STARVE_LIMIT.
  - It clears on lat_accept or when !lat_wb_valid.
  - drain = (starve_cnt==STARVE_LIMIT). It blocks all new issue until the long-latency result is accepted, so in-flight ALU ops drain and free the port.
- Reset mid-operation: all pending and outstanding state is discarded. Completion units must be flushed by the same reset.

Decomposition:
- Package rv32_pkg:
  - REG_IDX_W=5, NUM_REGS=32
  - typedef reg_idx_t
  - typedef wb_req_t {valid, index, data}
- Optional sub-module rv32_mod_wb_arbiter: two-input fixed-priority write-port mux with starvation counter.
- Scoreboard bitmap/counter stays in the top module.

Test Plan:
- Issue long rd=5 (accept), next cycle issue ALU rs1=5 rs1_use=1 -> issue_stall=1. lat_wb idx5 data 0xDEADBEEF with no ALU -> rf_write0_enable=1, idx5, pending[5]=0 next cycle, stall drops the cycle after.
- Same cycle alu_wb idx3 data 0x11 and lat_wb idx7 -> write port carries idx3/0x11, lat_wb_ready=0. Next cycle with no ALU -> idx7 written, ready=1.
- ALU writeback every cycle and lat_wb_valid held -> after 8 refused cycles issue_stall=1 for any issue_valid. Once ALU idle, lat accepted and stall releases.
- Issue 4 long ops rd=1..4 -> outstanding=4, 5th long issue (rd=9) stalls, an ALU op on x10 is not stalled. One completion -> 5th accepted the next cycle.
- lat_wb idx12 with pending[12]=0 -> sb_error=1 and stays 1. Long op with rd=0 -> pending unchanged, outstanding+1.
- Assert reset with pending=0x0000_0024 and outstanding=2 -> next cycle all zero. During reset issue_stall=1 and rf_write0_enable=0 even with alu_wb_valid=1.
